// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and default bit timing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_t;

  // Even parity: the XOR of all data bits plus the parity bit must be 0.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous input plus a third flop for falling-edge detection.
// Flops reset high so an idle-high line never produces a spurious edge out of reset.
module rx_sync (
  input  logic CLK,
  input  logic RST,
  input  logic D_ASYNC,
  output logic D_SYNC,
  output logic FALL
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= D_ASYNC;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign D_SYNC = sync_reg;
  assign FALL   = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_recv.sv
// UART receiver, 8N1 LSB first, with start-glitch rejection and framing-error flag.
// Define UART_RECV_PARITY_EN for 8E1 framing with a PARITY_ERR pulse output.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_READY,
  output logic                 FRAME_ERR,
`ifdef UART_RECV_PARITY_EN
  output logic                 PARITY_ERR,
`endif
  output logic                 BUSY
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rxd_sync;
  logic rxd_fall;

  rx_sync u_rx_sync (
    .CLK     (CLK),
    .RST     (RST),
    .D_ASYNC (RXD),
    .D_SYNC  (rxd_sync),
    .FALL    (rxd_fall)
  );

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 ready_reg, ready_next;
  logic                 ferr_reg, ferr_next;
  logic                 stop_ok;
`ifdef UART_RECV_PARITY_EN
  logic                 par_reg, par_next;
  logic                 perr_reg, perr_next;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_reg   <= 1'b0;
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      ferr_reg  <= ferr_next;
`ifdef UART_RECV_PARITY_EN
      par_reg   <= par_next;
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    ready_next = 1'b0;
    ferr_next  = 1'b0;
    stop_ok    = 1'b0;
`ifdef UART_RECV_PARITY_EN
    par_next   = par_reg;
    perr_next  = 1'b0;
`endif

    unique case (state_reg)
      S_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line stuck low stays idle.
        if (rxd_fall) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end

      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rxd_sync) begin
            state_next = S_DATA;
            idx_next   = '0;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rxd_sync;
          if (idx_reg == IDX_LAST) begin
`ifdef UART_RECV_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

`ifdef UART_RECV_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          par_next   = rxd_sync;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          // Leave mid stop bit so the next start edge can follow without an idle gap.
          state_next = S_IDLE;
          stop_ok    = rxd_sync;
          if (!stop_ok) begin
            ferr_next = 1'b1;
`ifdef UART_RECV_PARITY_EN
          end else if (parity_bad(shift_reg, par_reg)) begin
            perr_next = 1'b1;
`endif
          end else begin
            data_next  = shift_reg;
            ready_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign DATA       = data_reg;
  assign DATA_READY = ready_reg;
  assign FRAME_ERR  = ferr_reg;
  assign BUSY       = (state_reg != S_IDLE);
`ifdef UART_RECV_PARITY_EN
  assign PARITY_ERR = perr_reg;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Directed testbench for uart_recv at CLKS_PER_BIT=16 with an event scoreboard.
module tb_uart_recv;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  logic [7:0] last_good = 8'h00;

  // kind: 0 = DATA_READY, 1 = FRAME_ERR, 2 = PARITY_ERR
  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     start;
  } exp_t;
  exp_t sb[$];

  uart_recv #(.CLKS_PER_BIT(CPB)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RXD        (rxd),
    .DATA       (data),
    .DATA_READY (data_ready),
    .FRAME_ERR  (frame_err),
`ifdef UART_RECV_PARITY_EN
    .PARITY_ERR (parity_err),
`endif
    .BUSY       (busy)
  );

`ifndef UART_RECV_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; the expected event is queued when the start bit begins.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    e.start = cyc;
    e.data  = b;
    e.kind  = 0;
    if (!stop) e.kind = 1;
`ifdef UART_RECV_PARITY_EN
    else if (par_flip) e.kind = 2;
`endif
    if (e.kind == 0) last_good = b;
    else e.data = last_good;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RECV_PARITY_EN
    drive_bit(^b ^ par_flip);
`else
    if (par_flip) rxd = 1'b1;
`endif
    drive_bit(stop);
  endtask

  // Monitor: every output strobe pops one scoreboard entry.
  always @(negedge clk) begin
    exp_t   e;
    int     kind;
    longint lat;
    if (!rst && (data_ready || frame_err || parity_err)) begin
      kind = data_ready ? 0 : (frame_err ? 1 : 2);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=kind%0d data=%0h expected=none", kind, data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("event_kind", 32'(kind), 32'(e.kind));
        check("event_data", {24'd0, data}, {24'd0, e.data});
        lat = cyc - e.start;
        checks++;
        assert (lat >= 153 && lat <= 156) else begin
          errors++;
          $error("FAIL latency observed=%0d expected=153..156", lat);
        end
      end
      check("strobe_exclusive", 32'(data_ready + frame_err + parity_err), 32'd1);
      $display("event kind=%0d data=%02h cycle=%0d", kind, data, cyc);
    end
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_data", {24'd0, data}, 32'h0);
    check("reset_ready", {31'd0, data_ready}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    idle(5);

    // Single byte 0x35
    send_frame(8'h35, 1'b1, 1'b0);
    idle(20);
    check("after_35_data", {24'd0, data}, 32'h35);
    check("after_35_busy", {31'd0, busy}, 32'd0);
    check("after_35_sb_empty", 32'(sb.size()), 32'd0);

    // Start glitch: 4 low cycles
    rxd = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rxd = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (8) begin @(posedge clk); #1; end
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_data_held", {24'd0, data}, 32'h35);
    idle(20);

    // Framing error on 0xA5, line then held low
    send_frame(8'hA5, 1'b0, 1'b0);
    rxd = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    check("ferr_line_low_busy", {31'd0, busy}, 32'd0);
    check("ferr_data_held", {24'd0, data}, 32'h35);
    check("ferr_sb_empty", 32'(sb.size()), 32'd0);
    idle(20);
    check("ferr_recover_busy", {31'd0, busy}, 32'd0);

    // Back-to-back '0'..'9'
    for (int c = 8'h30; c <= 8'h39; c++) send_frame(8'(c), 1'b1, 1'b0);
    idle(20);
    check("stream_last_data", {24'd0, data}, 32'h39);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 of 0xFF
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (3 * CPB + CPB / 2) begin @(posedge clk); #1; end
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    check("midreset_data", {24'd0, data}, 32'h0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ready", {31'd0, data_ready}, 32'd0);
    check("midreset_ferr", {31'd0, frame_err}, 32'd0);
    idle(6 * CPB);
    check("midreset_no_event", 32'(sb.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("after_reset_5A", {24'd0, data}, 32'h5A);

    // Loopback-style bytes
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("loop_last_data", {24'd0, data}, 32'h55);
`ifdef UART_RECV_PARITY_EN
    send_frame(8'h55, 1'b1, 1'b1);
    idle(20);
    check("parity_data_held", {24'd0, data}, 32'h55);
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(20);
`endif
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
